// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion datapath.
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  // True when a nibble is not a legal decimal digit.
  function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: y = a*10 + d using shifts only.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned ACC_W = 20
) (
  input  logic [ACC_W-1:0]       a,
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [ACC_W-1:0]       y
);

  assign y = (a << 3) + (a << 1) + ACC_W'(d);

endmodule

// File: rtl/bcd_to_bin16.sv
// Iterative BCD-to-binary converter, most significant digit first, one digit per clock.
module bcd_to_bin16
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 5,
  parameter int unsigned OUT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] bcdIn,
  output logic [OUT_W-1:0]             outBin,
  output logic                         busy,
  output logic                         done,
  output logic                         err_digit,
  output logic                         err_overflow
);

  localparam int unsigned ACC_W = BCD_DIGIT_W * NDIGITS;
  localparam int unsigned CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  state_t           state;
  logic [ACC_W-1:0] dreg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next_c;
  logic [CNT_W-1:0] cnt;
  logic             dig_bad;
  logic             in_bad_c;
  logic             ovf_c;

  bcd_mac10 #(.ACC_W(ACC_W)) u_mac (
    .a(acc),
    .d(dreg[ACC_W-1 -: BCD_DIGIT_W]),
    .y(acc_next_c)
  );

  // Digit legality is judged once, on the word captured at start.
  always_comb begin
    in_bad_c = 1'b0;
    for (int k = 0; k < int'(NDIGITS); k++) begin
      in_bad_c = in_bad_c | digit_bad(bcdIn[BCD_DIGIT_W*k +: BCD_DIGIT_W]);
    end
  end

  // Accumulator is wide enough for any valid word, so overflow is just nonzero upper bits.
  generate
    if (ACC_W > OUT_W) begin : g_ovf
      assign ovf_c = |acc_next_c[ACC_W-1:OUT_W];
    end else begin : g_no_ovf
      assign ovf_c = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dreg         <= '0;
      acc          <= '0;
      cnt          <= '0;
      dig_bad      <= 1'b0;
      outBin       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_digit    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dreg    <= bcdIn;
            acc     <= '0;
            cnt     <= '0;
            dig_bad <= in_bad_c;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_next_c;
          dreg <= dreg << BCD_DIGIT_W;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            err_digit    <= dig_bad;
            err_overflow <= !dig_bad && ovf_c;
            outBin       <= dig_bad ? '0 : (ovf_c ? '1 : OUT_W'(acc_next_c));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
